counter_2bit_monitor: RTL

- Sits directly downstream of the 2-bit up/down counter (counter_2bit). It observes the counter's direction input x and its outputs q1/q0 on the same clock.
- Checks every counter step for legality and accumulates a signed-modulo wrap count (revolutions).
- Latches the first illegal step as a sticky error with a cause code. Used as an on-board self-check and as the source of a coarse revolution count for display logic.

---
 rtl/counter_mon_pkg.sv | 20 ++
 rtl/counter_step_classify.sv | 44 ++++
 rtl/counter_2bit_monitor.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_mon_pkg.sv
// rtl/counter_mon_pkg.sv - shared state and error-code encodings for the counter monitor
package counter_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIR  = 2'b01;
  localparam logic [1:0] ERR_SKIP = 2'b10;
  localparam logic [1:0] ERR_HOLD = 2'b11;

  // Forward distance from the previous counter value, modulo 4.
  function automatic logic [1:0] step_delta(input logic [1:0] q_prev, input logic [1:0] q);
    return q - q_prev;
  endfunction

endpackage

// File: rtl/counter_step_classify.sv
// rtl/counter_step_classify.sv - combinational legality and wrap classification of one counter step
module counter_step_classify
  import counter_mon_pkg::*;
#(
  parameter int ALLOW_HOLD = 0
) (
  input  logic [1:0] q_prev,
  input  logic [1:0] q,
  input  logic       x_prev,
  output logic       legal,
  output logic       up_wrap_c,
  output logic       dn_wrap_c,
  output logic [1:0] code
);

  logic [1:0] delta;

  always_comb begin
    delta     = step_delta(q_prev, q);
    legal     = 1'b0;
    code      = ERR_NONE;
    up_wrap_c = x_prev && (q_prev == 2'd3) && (q == 2'd0);
    dn_wrap_c = !x_prev && (q_prev == 2'd0) && (q == 2'd3);
    case (delta)
      2'd0: begin
        legal = (ALLOW_HOLD != 0);
        code  = legal ? ERR_NONE : ERR_HOLD;
      end
      2'd1: begin
        legal = x_prev;
        code  = x_prev ? ERR_NONE : ERR_DIR;
      end
      2'd2: begin
        legal = 1'b0;
        code  = ERR_SKIP;
      end
      default: begin
        legal = !x_prev;
        code  = x_prev ? ERR_DIR : ERR_NONE;
      end
    endcase
  end

endmodule

// File: rtl/counter_2bit_monitor.sv
// rtl/counter_2bit_monitor.sv - step checker and signed revolution counter for a 2-bit up/down counter
module counter_2bit_monitor
  import counter_mon_pkg::*;
#(
  parameter int WRAP_W     = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              x,
  input  logic              q0,
  input  logic              q1,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              up_wrap,
  output logic              dn_wrap,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              active
);

  state_t     state;
  logic [1:0] q_prev;
  logic       x_prev;
  logic [1:0] q_now;
  logic       legal;
  logic       up_wrap_c;
  logic       dn_wrap_c;
  logic [1:0] code;

  assign q_now = {q1, q0};

  counter_step_classify #(
    .ALLOW_HOLD(ALLOW_HOLD)
  ) u_classify (
    .q_prev    (q_prev),
    .q         (q_now),
    .x_prev    (x_prev),
    .legal     (legal),
    .up_wrap_c (up_wrap_c),
    .dn_wrap_c (dn_wrap_c),
    .code      (code)
  );

  // The counter output seen at this edge was produced with last edge's x,
  // so q_prev/x_prev are refreshed every edge regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      q_prev     <= 2'd0;
      x_prev     <= 1'b0;
      wrap_count <= '0;
      up_wrap    <= 1'b0;
      dn_wrap    <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      active     <= 1'b0;
    end else begin
      q_prev  <= q_now;
      x_prev  <= x;
      up_wrap <= 1'b0;
      dn_wrap <= 1'b0;
      if (clr) begin
        state      <= IDLE;
        wrap_count <= '0;
        err        <= 1'b0;
        err_code   <= ERR_NONE;
        active     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= TRACK;
            active <= 1'b1;
          end
          TRACK: begin
            if (legal) begin
              if (up_wrap_c) begin
                wrap_count <= wrap_count + WRAP_W'(1);
                up_wrap    <= 1'b1;
              end else if (dn_wrap_c) begin
                wrap_count <= wrap_count - WRAP_W'(1);
                dn_wrap    <= 1'b1;
              end
            end else begin
              state    <= ERROR;
              err      <= 1'b1;
              err_code <= code;
              active   <= 1'b0;
            end
          end
          ERROR: begin
            active <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
